irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
// PURPOSE
//  Parametrised 68000 interrupt controller. Generalises the hard-wired 3-source edge IRQ logic in the
//  system top to NUM_SRC sources, each with per-source enable, edge/level mode, polarity, software
//  force and W1C pending. Sits on the CPU bus as a 16-bit register slave and drives IPL2n..IPL0n.
//  Acknowledge comes from the bus decode (FC==3'b111). Autovector VPAn generation stays in the top.
// PARAMETERS
//  NUM_SRC      7   number of sources, 1..7; source i maps to IPL level i+1
//  SYNC_STAGES  2   input synchroniser flops per source, 0..3 (0 = src used directly)
// PORTS
//  clk         in   1        system clock
//  reset       in   1        synchronous, active-high
//  src         in   NUM_SRC  raw interrupt request lines
//  cs          in   1        register block select
//  wr          in   2        byte write strobes {upper,lower}; only wr[0] has effect (bits 15:8 reserved)
//  address     in   3        word register index
//  din         in   16       write data
//  dout        out  16       read data, combinational from address; 0 when cs=0
//  iack        in   1        CPU interrupt acknowledge cycle active (may be held many cycles)
//  iack_level  in   3        level being acknowledged (CPU address bits 3:1 during ack)
//  ipl_n       out  3        active-low encoded priority level to CPU
// BEHAVIOUR
//  Registers (bits NUM_SRC-1:0 valid, rest read 0, writes ignored):
//   0 PENDING  R / W1C     1 ENABLE  RW, reset 0     2 MODE  RW 1=edge 0=level, reset all 1
//   3 POLARITY RW 1=active-high/rising, reset all 1    4 FORCE W, 1 sets pending (edge-mode only), reads 0
//   5 STATUS   R [2:0]=current level, [15]=|(PENDING&ENABLE)    6,7 read 0
//  - s[i] = synchronised src[i] XOR ~POLARITY[i]; s_prev[i] updated every cycle regardless of mode.
//  - Edge mode: pending[i] set on s 0->1; cleared by W1C or by iack of level i+1.
//  - Set beats clear: edge or FORCE in same cycle as W1C/iack clear -> pending stays 1.
//  - Level mode: pending[i] <= s[i] every cycle; W1C, FORCE and iack have no effect.
//  - Mode change edge->level: pending follows s next cycle. Level->edge: pending keeps value,
//    no spurious edge (s_prev tracked continuously).
//  - POLARITY write that flips s 0->1 in edge mode is a genuine edge and sets pending.
//  - ENABLE gates level selection only; masking never clears pending; unmasking raises immediately.
//  - level = (highest i with pending[i]&ENABLE[i]) + 1, else 0; ipl_n <= ~level, registered.
//  - Ack: acts on rising edge of iack only (internal iack_prev). If iack_level == L, 1<=L<=NUM_SRC,
//    source L-1 in edge mode: pending[L-1] cleared. Otherwise (spurious/level mode/L=0) no change.
//  - Latency: src edge -> PENDING bit after SYNC_STAGES+1 cycles; ipl_n one cycle later.
//    Register write -> effect on next clock; ipl_n reflects it one further cycle.
//  - Reads have no side effects.
//  - Reset: pending 0, ENABLE 0, MODE all 1, POLARITY all 1, sync/s_prev/iack_prev 0, ipl_n 3'b111.
//    Reset asserted mid-ack or mid-edge discards all state; no event survives reset.
//  - s_prev resets to 0, so a source already active at reset release registers an edge.
// TESTING
//  1 Reset: read regs -> PENDING=0, ENABLE=0, MODE=0x007F, POLARITY=0x007F, STATUS=0, ipl_n=3'b111.
//  2 ENABLE=0x04, src[2] 0->1 -> PENDING=0x0004 at cycle 3, ipl_n=3'b100 at cycle 4; iack rise with
//    iack_level=3 -> PENDING=0, ipl_n=3'b111; held iack has no further effect.
//  3 ENABLE=0x7F, FORCE=0x05 -> STATUS=0x8003; ack level 3 -> STATUS=0x8001; W1C 0x01 -> STATUS=0.
//  4 MODE=0x7E, ENABLE=0x01, src[0]=1 -> PENDING bit0=1, W1C 0x01 ignored; src[0]=0 -> bit0=0 after 3 cycles.
//  5 W1C 0x02 in same cycle as synchronised rising edge on source 1 -> PENDING bit1 remains 1.
//  6 PENDING=0x01, ack with iack_level=5 -> no register change; POLARITY bit1 1->0 while src[1]=0 -> bit1 set.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// CPU-side register bus and interrupt-acknowledge signals between the 68000 bus decode and
// irq_ctrl.
interface irq_ctrl_if;
  logic        cs;
  logic [1:0]  wr;
  logic [2:0]  address;
  logic [15:0] din;
  logic [15:0] dout;
  logic        iack;
  logic [2:0]  iack_level;

  modport master (output cs, wr, address, din, iack, iack_level, input dout);
  modport slave  (input cs, wr, address, din, iack, iack_level, output dout);
endinterface

// File: rtl/irq_ctrl.sv
// Parametrised 68000 interrupt controller: NUM_SRC sources with enable, edge/level mode, polarity,
// software force and W1C pending, encoded onto the active-low IPL lines.
module irq_ctrl #(
  parameter int unsigned NUM_SRC     = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  irq_ctrl_if.slave          bus,
  output logic [2:0]         ipl_n
);

  localparam int unsigned PadW = 16 - NUM_SRC;

  logic [NUM_SRC-1:0] src_sync;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign src_sync = src;
  end else begin : g_sync
    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
        sync_q[0] <= src;
        for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
    end
    assign src_sync = sync_q[SYNC_STAGES-1];
  end

  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, mode_q, polarity_q, s_prev_q;
  logic               iack_prev_q;
  logic [2:0]         ipl_n_q;

  logic [NUM_SRC-1:0] s, rise, force_set, w1c_clr, ack_clr, active;
  logic               we;
  logic [2:0]         level;
  logic [15:0]        rdata;
  logic               unused_bits;

  // s_prev follows s in every mode, so a level->edge switch never fakes an edge.
  assign s         = src_sync ^ ~polarity_q;
  assign rise      = s & ~s_prev_q;
  assign we        = bus.cs & bus.wr[0];
  assign force_set = (we && bus.address == 3'd4) ? bus.din[NUM_SRC-1:0] : '0;
  assign w1c_clr   = (we && bus.address == 3'd0) ? bus.din[NUM_SRC-1:0] : '0;
  assign active    = pending_q & enable_q;

  always_comb begin
    ack_clr = '0;
    if (bus.iack && !iack_prev_q) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (bus.iack_level == 3'(i + 1)) ack_clr[i] = 1'b1;
      end
    end
  end

  // Edge mode: set beats clear. Level mode: pending mirrors s.
  assign pending_d = (mode_q & (rise | force_set | (pending_q & ~(w1c_clr | ack_clr))))
                   | (~mode_q & s);

  always_comb begin
    level = 3'd0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (active[i]) level = 3'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q   <= '0;
      enable_q    <= '0;
      mode_q      <= '1;
      polarity_q  <= '1;
      s_prev_q    <= '0;
      iack_prev_q <= 1'b0;
      ipl_n_q     <= 3'b111;
    end else begin
      pending_q   <= pending_d;
      s_prev_q    <= s;
      iack_prev_q <= bus.iack;
      ipl_n_q     <= ~level;
      if (we) begin
        case (bus.address)
          3'd1:    enable_q   <= bus.din[NUM_SRC-1:0];
          3'd2:    mode_q     <= bus.din[NUM_SRC-1:0];
          3'd3:    polarity_q <= bus.din[NUM_SRC-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.cs) begin
      case (bus.address)
        3'd0:    rdata = {{PadW{1'b0}}, pending_q};
        3'd1:    rdata = {{PadW{1'b0}}, enable_q};
        3'd2:    rdata = {{PadW{1'b0}}, mode_q};
        3'd3:    rdata = {{PadW{1'b0}}, polarity_q};
        3'd5:    rdata = {|active, 12'd0, level};
        default: rdata = '0;
      endcase
    end
  end

  assign bus.dout    = rdata;
  assign ipl_n       = ipl_n_q;
  assign unused_bits = ^{bus.wr[1], bus.din[15:NUM_SRC]};

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a per-cycle behavioural model checked against dout/ipl_n on every
// falling edge, plus literal expectations for the key scenarios.
module tb_irq_ctrl;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] src = '0;
  logic [2:0] ipl_n;
  logic       chk_en = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  irq_ctrl_if bus ();

  irq_ctrl #(.NUM_SRC(7), .SYNC_STAGES(SYNC)) dut (
    .clk  (clk),
    .reset(reset),
    .src  (src),
    .bus  (bus),
    .ipl_n(ipl_n)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [6:0] m_pend, m_en, m_mode, m_pol, m_sprev;
  logic       m_iack_prev;
  logic [2:0] m_ipl;
  logic [6:0] m_q[$];

  function automatic logic [2:0] m_level();
    for (int i = 6; i >= 0; i--) if (m_pend[i] && m_en[i]) return 3'(i + 1);
    return 3'd0;
  endfunction

  function automatic logic [15:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return {9'd0, m_pend};
      3'd1: return {9'd0, m_en};
      3'd2: return {9'd0, m_mode};
      3'd3: return {9'd0, m_pol};
      3'd5: return {(m_pend & m_en) != 7'd0, 12'd0, m_level()};
      default: return 16'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    logic [6:0] sv, nxt;
    logic       we;
    int         ack;
    if (reset) begin
      m_pend = '0; m_en = '0; m_mode = '1; m_pol = '1; m_sprev = '0;
      m_iack_prev = 1'b0; m_ipl = 3'b111;
      m_q = {};
      for (int k = 0; k < SYNC; k++) m_q.push_back(7'd0);
    end else begin
      sv = m_q[0] ^ ~m_pol;
      m_q.push_back(src);
      void'(m_q.pop_front());
      m_ipl = ~m_level();
      we  = bus.cs && bus.wr[0];
      ack = (bus.iack && !m_iack_prev) ? int'(bus.iack_level) : 0;
      for (int i = 0; i < 7; i++) begin
        if (!m_mode[i]) nxt[i] = sv[i];
        else if ((sv[i] && !m_sprev[i]) || (we && bus.address == 3'd4 && bus.din[i])) nxt[i] = 1'b1;
        else if ((we && bus.address == 3'd0 && bus.din[i]) || ack == i + 1) nxt[i] = 1'b0;
        else nxt[i] = m_pend[i];
      end
      m_pend = nxt;
      m_sprev = sv;
      m_iack_prev = bus.iack;
      if (we && bus.address == 3'd1) m_en = bus.din[6:0];
      if (we && bus.address == 3'd2) m_mode = bus.din[6:0];
      if (we && bus.address == 3'd3) m_pol = bus.din[6:0];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model ipl_n", {13'd0, ipl_n}, {13'd0, m_ipl});
      chk("model dout", bus.dout, bus.cs ? m_read(bus.address) : 16'd0);
    end
  end

  task automatic wrt(input logic [2:0] a, input logic [15:0] d);
    @(posedge clk); #2;
    bus.cs = 1'b1; bus.wr = 2'b01; bus.address = a; bus.din = d;
    @(posedge clk); #2;
    bus.cs = 1'b0; bus.wr = 2'b00; bus.din = '0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string name);
    @(posedge clk); #2;
    bus.cs = 1'b1; bus.wr = 2'b00; bus.address = a;
    @(negedge clk);
    chk(name, bus.dout, exp);
    @(posedge clk); #2;
    bus.cs = 1'b0;
  endtask

  task automatic ack(input logic [2:0] lvl);
    @(posedge clk); #2;
    bus.iack = 1'b1; bus.iack_level = lvl;
    repeat (2) @(posedge clk);
    #2 bus.iack = 1'b0;
  endtask

  task automatic set_src(input logic [6:0] v, input int settle);
    @(posedge clk); #2 src = v;
    repeat (settle) @(posedge clk);
  endtask

  initial begin
    logic [15:0] exp_p[5];
    logic [2:0]  exp_i[5];
    bus.cs = 0; bus.wr = 0; bus.address = 0; bus.din = 0; bus.iack = 0; bus.iack_level = 0;
    repeat (3) @(posedge clk);
    #2 chk_en = 1'b1;
    @(posedge clk); #2 reset = 1'b0;

    // Reset values
    chk("reset ipl_n", {13'd0, ipl_n}, 16'h0007);
    rd(3'd0, 16'h0000, "reset PENDING");
    rd(3'd1, 16'h0000, "reset ENABLE");
    rd(3'd2, 16'h007F, "reset MODE");
    rd(3'd3, 16'h007F, "reset POLARITY");
    rd(3'd5, 16'h0000, "reset STATUS");

    // Edge latency on source 2, then acknowledge at level 3
    wrt(3'd1, 16'h0004);
    exp_p = '{16'h0, 16'h0, 16'h0, 16'h4, 16'h4};
    exp_i = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b100};
    @(posedge clk); #2 src = 7'h04; bus.cs = 1'b1; bus.address = 3'd0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("edge latency PENDING", bus.dout, exp_p[k]);
      chk("edge latency ipl_n", {13'd0, ipl_n}, {13'd0, exp_i[k]});
    end
    @(posedge clk); #2 bus.iack = 1'b1; bus.iack_level = 3'd3;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("ack clears PENDING", bus.dout, 16'h0000);
    chk("ack ipl_n idle", {13'd0, ipl_n}, 16'h0007);
    @(posedge clk); #2 bus.iack = 1'b0; bus.cs = 1'b0;

    // FORCE, ack level 3, W1C
    set_src(7'h00, 4);
    wrt(3'd1, 16'h007F);
    wrt(3'd4, 16'h0005);
    rd(3'd5, 16'h8003, "force STATUS");
    ack(3'd3);
    rd(3'd5, 16'h8001, "ack3 STATUS");
    wrt(3'd0, 16'h0001);
    rd(3'd5, 16'h0000, "w1c STATUS");

    // Level mode on source 0
    wrt(3'd2, 16'h007E);
    wrt(3'd1, 16'h0001);
    set_src(7'h01, 4);
    rd(3'd0, 16'h0001, "level PENDING");
    wrt(3'd0, 16'h0001);
    rd(3'd0, 16'h0001, "level ignores W1C");
    @(posedge clk); #2 src = 7'h00; bus.cs = 1'b1; bus.address = 3'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("level follow", bus.dout, (k < 3) ? 16'h0001 : 16'h0000);
    end
    @(posedge clk); #2 bus.cs = 1'b0;

    // W1C coincides with synchronised rising edge on source 1
    @(posedge clk); #2 src = 7'h02;
    @(posedge clk); #2;
    @(posedge clk); #2 bus.cs = 1'b1; bus.wr = 2'b01; bus.address = 3'd0; bus.din = 16'h0002;
    @(posedge clk); #2 bus.wr = 2'b00; bus.din = '0;
    @(negedge clk);
    chk("set beats W1C", bus.dout, 16'h0002);
    @(posedge clk); #2 bus.cs = 1'b0;

    // Spurious ack level and polarity-induced edge
    wrt(3'd0, 16'h0002);
    wrt(3'd2, 16'h007F);
    wrt(3'd4, 16'h0001);
    rd(3'd0, 16'h0001, "force PENDING");
    ack(3'd5);
    rd(3'd0, 16'h0001, "spurious ack");
    set_src(7'h00, 4);
    wrt(3'd3, 16'h007D);
    rd(3'd0, 16'h0003, "polarity edge");

    // Reset mid-ack with a source held active
    @(posedge clk); #2 src = 7'h01; reset = 1'b1; bus.iack = 1'b1; bus.iack_level = 3'd1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0; bus.iack = 1'b0;
    rd(3'd0, 16'h0000, "post-reset PENDING");
    rd(3'd3, 16'h007F, "post-reset POLARITY");
    repeat (4) @(posedge clk);
    rd(3'd0, 16'h0001, "active at release");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
